key_scan_ctrl: RTL and testbench

KEY_SCAN_CTRL -- requirements
Module: key_scan_ctrl

---
 rtl/key_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_key_scan_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_scan_ctrl.sv
// 4x3 keypad scanner: row sweep, press/release debounce, and a four-digit BCD
// entry buffer ('*' clears, '#' commits).
module key_scan_ctrl #(
   parameter int SCAN_DIV = 8192,
   parameter int DEB_CNT  = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  column,
   output logic [2:0]  sel,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic        key_held,
   output logic [15:0] digits,
   output logic [2:0]  digit_cnt,
   output logic        entry_done
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEB_CNT + 1);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;

   state_t         state;
   logic [DW-1:0]  div_cnt;
   logic [CW-1:0]  deb, rel;
   logic [1:0]     row;
   logic [2:0]     cand_col;
   logic [3:0]     cand_code;
   logic           done_flag;
   logic           tick, hit, fire;
   logic [1:0]     col_idx;
   logic [3:0]     hit_code, fire_code;

   assign tick = (div_cnt == DW'(SCAN_DIV - 1));
   assign hit  = (column == 3'b011) || (column == 3'b101) || (column == 3'b110);
   assign sel  = {1'b0, row};

   always_comb begin
      col_idx = 2'd0;
      if (column == 3'b101)      col_idx = 2'd1;
      else if (column == 3'b110) col_idx = 2'd2;
      hit_code = 4'hF;
      if (row != 2'd3)
         hit_code = {2'b00, row} * 4'd3 + {2'b00, col_idx} + 4'd1;
      else
         case (col_idx)
            2'd0:    hit_code = 4'hA;
            2'd1:    hit_code = 4'h0;
            default: hit_code = 4'hB;
         endcase
   end

   // A press is confirmed on the tick that brings the match count to DEB_CNT.
   assign fire = tick && (((state == DEBOUNCE) && (column == cand_col) &&
                           (deb == CW'(DEB_CNT - 1))) ||
                          ((DEB_CNT <= 1) && (state == SCAN) && hit));
   assign fire_code = (state == SCAN) ? hit_code : cand_code;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= SCAN;
         div_cnt    <= '0;
         deb        <= '0;
         rel        <= '0;
         row        <= 2'd0;
         cand_col   <= 3'b111;
         cand_code  <= 4'hF;
         key_valid  <= 1'b0;
         key_code   <= 4'hF;
         key_held   <= 1'b0;
         digits     <= '0;
         digit_cnt  <= '0;
         entry_done <= 1'b0;
         done_flag  <= 1'b0;
      end else begin
         div_cnt    <= tick ? '0 : div_cnt + 1'b1;
         key_valid  <= 1'b0;
         // '#' leaves digit_cnt untouched, so the count seen alongside the strobe
         // is the one the key was judged against.
         entry_done <= key_valid && (key_code == 4'hB) && (digit_cnt != 3'd0);
         if (tick) begin
            case (state)
               SCAN:
                  if (hit) begin
                     cand_code <= hit_code;
                     cand_col  <= column;
                     deb       <= CW'(1);
                     state     <= DEBOUNCE;
                  end else
                     row <= row + 2'd1;
               DEBOUNCE:
                  if (column == cand_col)
                     deb <= deb + 1'b1;
                  else begin
                     deb   <= '0;
                     row   <= row + 2'd1;
                     state <= SCAN;
                  end
               HOLD:
                  if (column != 3'b111)
                     rel <= '0;
                  else if (rel == CW'(DEB_CNT - 1)) begin
                     rel      <= '0;
                     key_held <= 1'b0;
                     state    <= SCAN;
                  end else
                     rel <= rel + 1'b1;
               default: state <= SCAN;
            endcase
         end
         if (fire) begin
            key_valid <= 1'b1;
            key_code  <= fire_code;
            key_held  <= 1'b1;
            deb       <= '0;
            rel       <= '0;
            state     <= HOLD;
            if (fire_code <= 4'd9) begin
               if (done_flag) begin
                  digits    <= {12'h000, fire_code};
                  digit_cnt <= 3'd1;
                  done_flag <= 1'b0;
               end else if (digit_cnt < 3'd4) begin
                  digits    <= {digits[11:0], fire_code};
                  digit_cnt <= digit_cnt + 3'd1;
               end
            end else if (fire_code == 4'hA) begin
               digits    <= '0;
               digit_cnt <= '0;
               done_flag <= 1'b0;
            end else if (digit_cnt != 3'd0)
               done_flag <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Bench for key_scan_ctrl: a keypad model answers the row select, and a
// key-sequence model predicts the code, entry buffer and commit strobes.
module tb_key_scan_ctrl;
   localparam int SD = 4;
   localparam int DC = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [2:0]  column;
   logic [2:0]  sel;
   logic        key_valid, key_held, entry_done;
   logic [3:0]  key_code;
   logic [15:0] digits;
   logic [2:0]  digit_cnt;

   key_scan_ctrl #(.SCAN_DIV(SD), .DEB_CNT(DC)) dut (
      .clk(clk), .reset(reset), .column(column), .sel(sel),
      .key_valid(key_valid), .key_code(key_code), .key_held(key_held),
      .digits(digits), .digit_cnt(digit_cnt), .entry_done(entry_done));

   always #5 clk = ~clk;

   // physical keypad: the pressed key pulls its column low only while its row is selected
   logic       pressed = 1'b0;
   logic       forced = 1'b0;
   logic [2:0] force_pat = 3'b111;
   int         prow = 0, pcol = 0;
   always @* begin
      if (forced) column = force_pat;
      else if (pressed && int'(sel) == prow) column = ~(3'b100 >> pcol);
      else column = 3'b111;
   end

   int nvec = 0, nerr = 0;
   int kv_cnt = 0, ed_cnt = 0, ed_bad = 0;
   logic prev_kv_b = 1'b0;
   always @(negedge clk) begin
      if (key_valid) kv_cnt++;
      if (entry_done) begin
         ed_cnt++;
         if (!prev_kv_b) ed_bad++;
      end
      prev_kv_b = key_valid && key_code == 4'hB;
   end

   // expected entry state, from the sequence of accepted keys
   int m_val = 0, m_n = 0, m_ed = 0;
   bit m_done = 0;
   function automatic void model_key(int k);
      if (k <= 9) begin
         if (m_done) begin m_val = k; m_n = 1; m_done = 0; end
         else if (m_n < 4) begin m_val = (m_val * 16 + k) % 65536; m_n++; end
      end else if (k == 10) begin
         m_val = 0; m_n = 0; m_done = 0;
      end else if (m_n > 0) begin
         m_done = 1; m_ed++;
      end
   endfunction

   // k: 0-9 digits, 10 '*', 11 '#'
   task automatic locate(input int k);
      if (k >= 1 && k <= 9) begin prow = (k - 1) / 3; pcol = (k - 1) % 3; end
      else begin prow = 3; pcol = (k == 10) ? 0 : (k == 0) ? 1 : 2; end
   endtask

   task automatic press(input int k, input int hold_cyc, input int rel_cyc);
      locate(k);
      pressed = 1'b1;
      repeat (hold_cyc) @(negedge clk);
      pressed = 1'b0;
      repeat (rel_cyc) @(negedge clk);
      model_key(k);
   endtask

   task automatic check_reset_vals(input string tag);
      nvec++; if (sel !== 3'd0) begin nerr++; $display("FAIL %s_sel got %0d want 0", tag, sel); end
      nvec++; if (key_valid !== 1'b0) begin nerr++; $display("FAIL %s_key_valid got %b want 0", tag, key_valid); end
      nvec++; if (key_code !== 4'hF) begin nerr++; $display("FAIL %s_key_code got %h want f", tag, key_code); end
      nvec++; if (key_held !== 1'b0) begin nerr++; $display("FAIL %s_key_held got %b want 0", tag, key_held); end
      nvec++; if (digits !== 16'h0) begin nerr++; $display("FAIL %s_digits got %h want 0", tag, digits); end
      nvec++; if (digit_cnt !== 3'd0) begin nerr++; $display("FAIL %s_digit_cnt got %0d want 0", tag, digit_cnt); end
      nvec++; if (entry_done !== 1'b0) begin nerr++; $display("FAIL %s_entry_done got %b want 0", tag, entry_done); end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_key;
      int k0 = kv_cnt;
      locate(5);
      pressed = 1'b1;
      repeat (SD * 20) @(negedge clk);
      nvec++; if (kv_cnt - k0 != 1) begin nerr++; $display("FAIL single_kv_count got %0d want 1", kv_cnt - k0); end
      nvec++; if (key_code !== 4'd5) begin nerr++; $display("FAIL single_code got %h want 5", key_code); end
      nvec++; if (digits !== 16'h0005) begin nerr++; $display("FAIL single_digits got %h want 0005", digits); end
      nvec++; if (digit_cnt !== 3'd1) begin nerr++; $display("FAIL single_cnt got %0d want 1", digit_cnt); end
      nvec++; if (key_held !== 1'b1) begin nerr++; $display("FAIL single_held got %b want 1", key_held); end
      pressed = 1'b0;
      repeat (2 * SD) @(negedge clk);
      nvec++; if (key_held !== 1'b1) begin nerr++; $display("FAIL single_held_2rel got %b want 1", key_held); end
      repeat (2 * SD) @(negedge clk);
      nvec++; if (key_held !== 1'b0) begin nerr++; $display("FAIL single_held_released got %b want 0", key_held); end
      model_key(5);
   endtask

   task automatic test_glitch;
      int k0 = kv_cnt;
      int t = 0, n = 0;
      int seq[4];
      logic [2:0] last;
      while (sel !== 3'd0 && t < 50) begin @(negedge clk); t++; end
      nvec++; if (t >= 50) begin nerr++; $display("FAIL glitch_wait_row0 got sel %0d want 0", sel); end
      forced = 1'b1; force_pat = 3'b011;
      repeat (SD) @(negedge clk);
      force_pat = 3'b111;
      last = sel; t = 0;
      while (n < 4 && t < 100) begin
         @(negedge clk); t++;
         if (sel !== last) begin seq[n] = int'(sel); n++; end
         last = sel;
      end
      forced = 1'b0;
      for (int i = 0; i < 4; i++) begin
         nvec++;
         if (i >= n || seq[i] != (i + 1) % 4) begin
            nerr++; $display("FAIL glitch_sel_seq%0d got %0d want %0d", i, (i < n) ? seq[i] : -1, (i + 1) % 4);
         end
      end
      nvec++; if (kv_cnt != k0) begin nerr++; $display("FAIL glitch_no_kv got %0d want 0", kv_cnt - k0); end
   endtask

   task automatic test_double_low;
      int k0 = kv_cnt;
      logic [3:0] seen = '0;
      forced = 1'b1; force_pat = 3'b001;
      repeat (SD * 20) begin @(negedge clk); seen[sel[1:0]] = 1'b1; end
      forced = 1'b0;
      nvec++; if (kv_cnt != k0) begin nerr++; $display("FAIL double_no_kv got %0d want 0", kv_cnt - k0); end
      nvec++; if (seen !== 4'hF) begin nerr++; $display("FAIL double_scan_rows got %b want 1111", seen); end
   endtask

   task automatic test_entry;
      int e0, k0;
      int keys[7] = '{10, 1, 2, 3, 4, 5, 11};
      e0 = ed_cnt; k0 = kv_cnt;
      foreach (keys[i]) press(keys[i], 48, 32);
      nvec++; if (kv_cnt - k0 != 7) begin nerr++; $display("FAIL entry_kv_count got %0d want 7", kv_cnt - k0); end
      nvec++; if (digits !== 16'h1234) begin nerr++; $display("FAIL entry_digits got %h want 1234", digits); end
      nvec++; if (digit_cnt !== 3'd4) begin nerr++; $display("FAIL entry_cnt got %0d want 4", digit_cnt); end
      nvec++; if (ed_cnt - e0 != 1) begin nerr++; $display("FAIL entry_done_count got %0d want 1", ed_cnt - e0); end
      press(7, 48, 32);
      nvec++; if (digits !== 16'h0007) begin nerr++; $display("FAIL entry_after_done_digits got %h want 0007", digits); end
      nvec++; if (digit_cnt !== 3'd1) begin nerr++; $display("FAIL entry_after_done_cnt got %0d want 1", digit_cnt); end
   endtask

   task automatic test_star_clear;
      int e0 = ed_cnt;
      int keys[4] = '{8, 9, 10, 11};
      foreach (keys[i]) press(keys[i], 48, 32);
      nvec++; if (digits !== 16'h0) begin nerr++; $display("FAIL star_digits got %h want 0", digits); end
      nvec++; if (digit_cnt !== 3'd0) begin nerr++; $display("FAIL star_cnt got %0d want 0", digit_cnt); end
      nvec++; if (ed_cnt != e0) begin nerr++; $display("FAIL star_no_done got %0d want 0", ed_cnt - e0); end
   endtask

   task automatic test_random;
      for (int it = 0; it < 24; it++) begin
         int k = $urandom_range(0, 11);
         int k0 = kv_cnt, e0 = ed_cnt, me0 = m_ed;
         press(k, $urandom_range(32, 64), $urandom_range(24, 40));
         nvec++; if (kv_cnt - k0 != 1) begin nerr++; $display("FAIL rnd%0d_kv got %0d want 1", it, kv_cnt - k0); end
         nvec++; if (key_code !== 4'(k)) begin nerr++; $display("FAIL rnd%0d_code got %h want %h", it, key_code, k); end
         nvec++; if (digits !== 16'(m_val)) begin nerr++; $display("FAIL rnd%0d_digits got %h want %h", it, digits, m_val); end
         nvec++; if (digit_cnt !== 3'(m_n)) begin nerr++; $display("FAIL rnd%0d_cnt got %0d want %0d", it, digit_cnt, m_n); end
         nvec++; if (ed_cnt - e0 != m_ed - me0) begin nerr++; $display("FAIL rnd%0d_done got %0d want %0d", it, ed_cnt - e0, m_ed - me0); end
      end
      nvec++; if (ed_bad != 0) begin nerr++; $display("FAIL done_timing got %0d stray pulses want 0", ed_bad); end
   endtask

   task automatic test_reset_hold;
      int k0;
      locate(9);
      pressed = 1'b1;
      repeat (40) @(negedge clk);
      nvec++; if (key_held !== 1'b1) begin nerr++; $display("FAIL rsthold_pre_held got %b want 1", key_held); end
      #2 reset = 1'b0;
      #1 check_reset_vals("rsthold");
      pressed = 1'b0;
      m_val = 0; m_n = 0; m_done = 0;
      @(negedge clk);
      reset = 1'b1;
      k0 = kv_cnt;
      repeat (60) @(negedge clk);
      nvec++; if (kv_cnt != k0) begin nerr++; $display("FAIL rsthold_no_kv got %0d want 0", kv_cnt - k0); end
      nvec++; if (key_code !== 4'hF) begin nerr++; $display("FAIL rsthold_code got %h want f", key_code); end
      nvec++; if (key_held !== 1'b0) begin nerr++; $display("FAIL rsthold_held got %b want 0", key_held); end
   endtask

   initial begin
      test_reset;
      test_single_key;
      test_glitch;
      test_double_low;
      test_entry;
      test_star_clear;
      test_random;
      test_reset_hold;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "timeout");
   end
endmodule
